// File: rtl/if_fetch_ctrl_if.sv
// if_fetch_ctrl_if: fetch-stage control inputs and PC / IF/ID outputs bundled as one port
interface if_fetch_ctrl_if;
    logic        Stall;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        Jump;
    logic [25:0] Jump_index;
    logic [31:0] Instr_in;
    logic [31:0] Address_out;
    logic [31:0] IFID_instr;
    logic [31:0] IFID_pc4;
    logic        IFID_valid;
    modport master (
        output Stall, Branch_taken, Branch_target, Jump, Jump_index, Instr_in,
        input  Address_out, IFID_instr, IFID_pc4, IFID_valid
    );
    modport slave (
        input  Stall, Branch_taken, Branch_target, Jump, Jump_index, Instr_in,
        output Address_out, IFID_instr, IFID_pc4, IFID_valid
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: PC register, next-PC select (branch > jump > stall > sequential) and IF/ID register
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input logic           Clk,
    input logic           Reset,
    if_fetch_ctrl_if.slave bus
);
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] redirect_pc;
    logic        redirect;
    assign pc4         = pc + 32'd4;
    assign redirect    = bus.Branch_taken | bus.Jump;
    // The branch is older than the jump in ID, so its target wins; jumps use the PC+4 held in IF/ID
    assign redirect_pc = bus.Branch_taken ? (bus.Branch_target & ~32'd3)
                                          : {ifid_pc4[31:28], bus.Jump_index, 2'b00};
    // PC and IF/ID update: redirect flushes, stall freezes, otherwise advance and capture the fetch
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc         <= RESET_ADDR;
            ifid_instr <= NOP_WORD;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc;
            ifid_instr <= NOP_WORD;
            ifid_pc4   <= 32'd0;
            ifid_valid <= 1'b0;
        end else if (!bus.Stall) begin
            pc         <= pc4;
            ifid_instr <= bus.Instr_in;
            ifid_pc4   <= pc4;
            ifid_valid <= 1'b1;
        end
    end
    assign bus.Address_out = pc;
    assign bus.IFID_instr  = ifid_instr;
    assign bus.IFID_pc4    = ifid_pc4;
    assign bus.IFID_valid  = ifid_valid;
endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Instruction-fetch control stage of the 4-stage pipeline. Sits directly upstream of the PC pass-through block and drives its Address_in.
- Holds the architectural PC register and selects next-PC: sequential, branch redirect, jump redirect, or stall hold.
- Captures the fetched instruction and its PC+4 into the IF/ID pipeline register, with flush on redirect and hold on stall.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 00.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Stall  input  1  hazard hold from ID (load-use); freezes PC and IF/ID
Branch_taken  input  1  branch resolved taken (EX stage)
Branch_target  input  32  branch destination byte address
Jump  input  1  J/JAL decoded in ID
Jump_index  input  26  instr[25:0] of the jump in ID
Instr_in  input  32  instruction memory read data for Address_out (combinational read, same cycle)
Address_out  output  32  current PC; feeds the PC block Address_in and instruction memory
IFID_instr  output  32  registered instruction to ID
IFID_pc4  output  32  registered PC+4 of IFID_instr
IFID_valid  output  1  1 = IFID_instr is a real fetched instruction; 0 = bubble

Behaviour:
- Reset (async, any time, including mid-redirect or mid-stall): Address_out=RESET_ADDR, IFID_instr=NOP_WORD, IFID_pc4=0, IFID_valid=0. All state updates on rising Clk only when Reset=0.
- pc4 = Address_out + 4, computed combinationally in 32 bits modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Jump target = {IFID_pc4[31:28], Jump_index, 2'b00}. It uses the PC+4 of the jump held in IF/ID, not the current PC.
- Branch_target is used with bits [1:0] forced to 00; no exception is raised.
- Next-state priority per edge, highest first:
  1. Branch_taken=1: PC<=Branch_target&~3. IF/ID flushed (instr=NOP_WORD, pc4=0, valid=0). Overrides Jump and Stall, because the branch is the older instruction.
  2. Jump=1: PC<=jump target. IF/ID flushed. Overrides Stall.
  3. Stall=1: PC and all IF/ID outputs hold their values.
  4. Otherwise: PC<=pc4, IFID_instr<=Instr_in, IFID_pc4<=pc4, IFID_valid<=1.
- Latency:
  - Instruction at address A appears on IFID_instr one edge after Address_out=A, provided no stall or redirect occurs that cycle.
  - Redirect penalty: 1 bubble for a jump. For a branch, 1 bubble in IF/ID; ID/EX flushing is the responsibility of the downstream stage.
- Stall held N cycles: PC and IF/ID frozen N cycles. Instr_in is re-read each cycle and is not captured until the Stall=0 edge.
- Redirect asserted while IFID_valid=0 is still honoured. The block does no qualification; upstream must gate Jump with valid.
- Address_out is registered and is never a combinational function of the inputs.
- No other state exists.

Test Plan:
- Reset release, RESET_ADDR=0, memory returns word=addr|0x1000_0000: Address_out sequence 0,4,8,C. IFID_valid rises on first edge. IFID_instr=0x1000_0000 with IFID_pc4=4, then 0x1000_0004 with pc4=8.
- Stall=1 for 3 cycles with Address_out=0x10: Address_out stays 0x10 and IFID stays at instr 0x1000_000C/pc4 0x10. On release, next edge gives IFID_instr=0x1000_0010 and Address_out=0x14.
- Jump=1, IFID_pc4=0x4000_0008, Jump_index=26'h000_0100: next Address_out=0x4000_0400, IFID_valid=0, IFID_instr=0. Following edge IFID_instr=word at 0x4000_0400.
- Branch_taken=1, Branch_target=0x0000_0203, with Jump=1 and Stall=1 the same cycle: Address_out=0x0000_0200 and IF/ID flushed. Jump and stall are ignored.
- Wrap: force PC to 0xFFFF_FFFC via branch, then free-run: next Address_out=0x0000_0000 and IFID_pc4=0x0000_0000.
- Async reset pulsed mid-cycle during a stall at PC=0x80: outputs go to RESET_ADDR/NOP/0/0 immediately, without waiting for Clk. Fetch resumes from RESET_ADDR after release.
